// File: rtl/load_unit.sv
// In-order load queue: takes up to two loads per cycle, snoops ALU/load broadcasts for base operands,
// issues the head to synchronous memory and broadcasts the result two cycles later. Option: LD_CAPTURE_BYPASS_EN.
module load_unit #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 10,
    parameter int TAG_W  = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              ld_disp1_i,
    input  logic              ld_disp2_i,
    input  logic              base_rdy1_i,
    input  logic              base_rdy2_i,
    input  logic [31:0]       base_val1_i,
    input  logic [31:0]       base_val2_i,
    input  logic [TAG_W-1:0]  base_tag1_i,
    input  logic [TAG_W-1:0]  base_tag2_i,
    input  logic [15:0]       offset1_i,
    input  logic [15:0]       offset2_i,
    input  logic [TAG_W-1:0]  dest_tag1_i,
    input  logic [TAG_W-1:0]  dest_tag2_i,
    input  logic [4:0]        dest1_i,
    input  logic [4:0]        dest2_i,
    input  logic              alu1_wr_i,
    input  logic              alu2_wr_i,
    input  logic [TAG_W-1:0]  alu1_res_tag_i,
    input  logic [TAG_W-1:0]  alu2_res_tag_i,
    input  logic [31:0]       alu1_res_i,
    input  logic [31:0]       alu2_res_i,
    output logic              mem_rd_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [31:0]       mem_rdata_i,
    output logic              ld_wr_o,
    output logic [TAG_W-1:0]  ld_res_tag_o,
    output logic [4:0]        ld_dest_o,
    output logic [31:0]       ld_val_o,
    output logic              full_LD_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0] ent_vld_q, ent_rdy_q;
    logic [31:0]      ent_bval_q [DEPTH];
    logic [TAG_W-1:0] ent_btag_q [DEPTH];
    logic [31:0]      ent_off_q  [DEPTH];
    logic [TAG_W-1:0] ent_dtag_q [DEPTH];
    logic [4:0]       ent_dst_q  [DEPTH];
    logic [32:0]      ent_sn     [DEPTH];

    logic [PW-1:0]     head_q, head_d, tail_q, tail_d, tail1;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0] mem_addr_q, iss_addr;
    logic [31:0]       iss_sum;
    logic              issue;

    // vld_pipe_q[0]: issued last cycle (data arriving), vld_pipe_q[1]: broadcasting now
    logic [1:0]       vld_pipe_q;
    logic [TAG_W-1:0] p1_tag_q, ld_tag_q;
    logic [4:0]       p1_dst_q, ld_dst_q;
    logic [31:0]      ld_val_q;

    // Broadcast match in priority order: alu1, alu2, then our own registered load result.
    function automatic logic [32:0] snoop(input logic [TAG_W-1:0] t);
        if (alu1_wr_i && alu1_res_tag_i == t) return {1'b1, alu1_res_i};
        if (alu2_wr_i && alu2_res_tag_i == t) return {1'b1, alu2_res_i};
        if (vld_pipe_q[1] && ld_tag_q == t)   return {1'b1, ld_val_q};
        return '0;
    endfunction

    always_comb begin
        for (int i = 0; i < DEPTH; i++) ent_sn[i] = snoop(ent_btag_q[i]);
    end

    // Slot A is the older dispatching load; slot B exists only when both dispatch.
    logic              wr_a, wr_b, a_rdy;
    logic [31:0]       a_val, a_off;
    logic [TAG_W-1:0]  a_btag, a_dtag;
    logic [4:0]        a_dst;
    logic [32:0]       a_sn, b_sn;

    assign wr_a   = !stall_i && (ld_disp1_i || ld_disp2_i);
    assign wr_b   = !stall_i && ld_disp1_i && ld_disp2_i;
    assign a_rdy  = ld_disp1_i ? base_rdy1_i : base_rdy2_i;
    assign a_val  = ld_disp1_i ? base_val1_i : base_val2_i;
    assign a_btag = ld_disp1_i ? base_tag1_i : base_tag2_i;
    assign a_off  = ld_disp1_i ? {{16{offset1_i[15]}}, offset1_i} : {{16{offset2_i[15]}}, offset2_i};
    assign a_dtag = ld_disp1_i ? dest_tag1_i : dest_tag2_i;
    assign a_dst  = ld_disp1_i ? dest1_i : dest2_i;

`ifdef LD_CAPTURE_BYPASS_EN
    assign a_sn = snoop(a_btag);
    assign b_sn = snoop(base_tag2_i);
`else
    assign a_sn = '0;
    assign b_sn = '0;
`endif

    assign issue    = ent_vld_q[head_q] && ent_rdy_q[head_q];
    assign iss_sum  = ent_bval_q[head_q] + ent_off_q[head_q];
    assign iss_addr = iss_sum[ADDR_W-1:0];
    assign tail1    = tail_q + PW'(1);
    assign tail_d   = tail_q + PW'(wr_a) + PW'(wr_b);
    assign head_d   = head_q + PW'(issue);
    assign cnt_d    = cnt_q + CW'(wr_a) + CW'(wr_b) - CW'(issue);

    assign mem_rd_o     = issue;
    assign mem_addr_o   = issue ? iss_addr : mem_addr_q;
    assign full_LD_o    = (CW'(DEPTH) - cnt_q) < CW'(2);
    assign ld_wr_o      = vld_pipe_q[1];
    assign ld_res_tag_o = ld_tag_q;
    assign ld_dest_o    = ld_dst_q;
    assign ld_val_o     = ld_val_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ent_vld_q <= '0;
            ent_rdy_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_bval_q[i] <= '0;
                ent_btag_q[i] <= '0;
                ent_off_q[i]  <= '0;
                ent_dtag_q[i] <= '0;
                ent_dst_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_vld_q[i] && !ent_rdy_q[i] && ent_sn[i][32]) begin
                    ent_rdy_q[i]  <= 1'b1;
                    ent_bval_q[i] <= ent_sn[i][31:0];
                end
            end
            if (issue) ent_vld_q[head_q] <= 1'b0;
            if (wr_a) begin
                ent_vld_q[tail_q]  <= 1'b1;
                ent_rdy_q[tail_q]  <= a_rdy || a_sn[32];
                ent_bval_q[tail_q] <= (!a_rdy && a_sn[32]) ? a_sn[31:0] : a_val;
                ent_btag_q[tail_q] <= a_btag;
                ent_off_q[tail_q]  <= a_off;
                ent_dtag_q[tail_q] <= a_dtag;
                ent_dst_q[tail_q]  <= a_dst;
            end
            if (wr_b) begin
                ent_vld_q[tail1]  <= 1'b1;
                ent_rdy_q[tail1]  <= base_rdy2_i || b_sn[32];
                ent_bval_q[tail1] <= (!base_rdy2_i && b_sn[32]) ? b_sn[31:0] : base_val2_i;
                ent_btag_q[tail1] <= base_tag2_i;
                ent_off_q[tail1]  <= {{16{offset2_i[15]}}, offset2_i};
                ent_dtag_q[tail1] <= dest_tag2_i;
                ent_dst_q[tail1]  <= dest2_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            head_q     <= '0;
            tail_q     <= '0;
            cnt_q      <= '0;
            mem_addr_q <= '0;
            vld_pipe_q <= '0;
            p1_tag_q   <= '0;
            p1_dst_q   <= '0;
            ld_tag_q   <= '0;
            ld_dst_q   <= '0;
            ld_val_q   <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            cnt_q      <= cnt_d;
            vld_pipe_q <= {vld_pipe_q[0], issue};
            if (issue) begin
                mem_addr_q <= iss_addr;
                p1_tag_q   <= ent_dtag_q[head_q];
                p1_dst_q   <= ent_dst_q[head_q];
            end
            if (vld_pipe_q[0]) begin
                ld_tag_q <= p1_tag_q;
                ld_dst_q <= p1_dst_q;
                ld_val_q <= mem_rdata_i;
            end
        end
    end
endmodule

// File: tb/tb_load_unit.sv
// Bench for load_unit: directed scenarios plus random traffic, checked against a queue-based model.
module tb_load_unit;
    localparam int DEPTH = 4;

    logic clk = 0, rst = 0, stall;
    logic ld_disp1, ld_disp2, base_rdy1, base_rdy2;
    logic [31:0] base_val1, base_val2, alu1_res, alu2_res, mem_rdata, ld_val;
    logic [4:0] base_tag1, base_tag2, dest_tag1, dest_tag2, dest1, dest2;
    logic [15:0] offset1, offset2;
    logic alu1_wr, alu2_wr, mem_rd, ld_wr, full_LD;
    logic [4:0] alu1_res_tag, alu2_res_tag, ld_res_tag, ld_dest;
    logic [9:0] mem_addr;

    load_unit #(.DEPTH(DEPTH), .ADDR_W(10), .TAG_W(5)) dut (
        .clk_i(clk), .rst_i(rst), .stall_i(stall),
        .ld_disp1_i(ld_disp1), .ld_disp2_i(ld_disp2),
        .base_rdy1_i(base_rdy1), .base_rdy2_i(base_rdy2),
        .base_val1_i(base_val1), .base_val2_i(base_val2),
        .base_tag1_i(base_tag1), .base_tag2_i(base_tag2),
        .offset1_i(offset1), .offset2_i(offset2),
        .dest_tag1_i(dest_tag1), .dest_tag2_i(dest_tag2),
        .dest1_i(dest1), .dest2_i(dest2),
        .alu1_wr_i(alu1_wr), .alu2_wr_i(alu2_wr),
        .alu1_res_tag_i(alu1_res_tag), .alu2_res_tag_i(alu2_res_tag),
        .alu1_res_i(alu1_res), .alu2_res_i(alu2_res),
        .mem_rd_o(mem_rd), .mem_addr_o(mem_addr), .mem_rdata_i(mem_rdata),
        .ld_wr_o(ld_wr), .ld_res_tag_o(ld_res_tag), .ld_dest_o(ld_dest),
        .ld_val_o(ld_val), .full_LD_o(full_LD)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:1023];
    always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

    typedef struct {
        logic        rdy;
        logic [31:0] val;
        logic [4:0]  btag;
        logic [31:0] off;
        logic [4:0]  dtag;
        logic [4:0]  dst;
    } ent_t;
    typedef struct {
        int          due;
        logic [4:0]  tag;
        logic [4:0]  dst;
        logic [31:0] val;
    } bc_t;

    ent_t q[$];
    bc_t  sched[$];
    int   cyc = 0;
    logic [9:0]  last_addr = '0;
    logic [31:0] last_val = '0;
    int nchk = 0, nerr = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [9:0] addr_of(input ent_t e);
        logic [31:0] s;
        s = e.val + e.off;
        return s[9:0];
    endfunction

    // Wake a waiting operand from whichever broadcast carries its tag this cycle.
    function automatic ent_t wake(input ent_t e, input logic bhit, input bc_t b);
        ent_t r = e;
        if (!e.rdy) begin
            if (alu1_wr && alu1_res_tag == e.btag)      begin r.rdy = 1; r.val = alu1_res; end
            else if (alu2_wr && alu2_res_tag == e.btag) begin r.rdy = 1; r.val = alu2_res; end
            else if (bhit && b.tag == e.btag)           begin r.rdy = 1; r.val = b.val; end
        end
        return r;
    endfunction

    function automatic ent_t mk(input logic r, input logic [31:0] v, input logic [4:0] bt,
                                input logic [15:0] o, input logic [4:0] dt, input logic [4:0] d);
        ent_t e;
        e.rdy = r; e.val = v; e.btag = bt; e.off = {{16{o[15]}}, o}; e.dtag = dt; e.dst = d;
        return e;
    endfunction

    task automatic model_step();
        logic bhit;
        bc_t b, nb;
        ent_t e;
        bhit = sched.size() > 0 && sched[0].due == cyc;
        if (bhit) b = sched[0];
        if (q.size() > 0 && q[0].rdy) begin
            last_addr = addr_of(q[0]);
            nb.due = cyc + 2; nb.tag = q[0].dtag; nb.dst = q[0].dst; nb.val = mem[last_addr];
            sched.push_back(nb);
            void'(q.pop_front());
        end
        foreach (q[i]) q[i] = wake(q[i], bhit, b);
        if (bhit) begin last_val = b.val; void'(sched.pop_front()); end
        if (!stall) begin
            if (ld_disp1) begin
                e = mk(base_rdy1, base_val1, base_tag1, offset1, dest_tag1, dest1);
`ifdef LD_CAPTURE_BYPASS_EN
                e = wake(e, bhit, b);
`endif
                q.push_back(e);
            end
            if (ld_disp2) begin
                e = mk(base_rdy2, base_val2, base_tag2, offset2, dest_tag2, dest2);
`ifdef LD_CAPTURE_BYPASS_EN
                e = wake(e, bhit, b);
`endif
                q.push_back(e);
            end
        end
    endtask

    task automatic check_outputs();
        logic iss, bhit;
        iss  = q.size() > 0 && q[0].rdy;
        bhit = sched.size() > 0 && sched[0].due == cyc;
        chk("full_LD", full_LD, 32'((DEPTH - q.size()) < 2));
        chk("mem_rd", mem_rd, iss);
        chk("mem_addr", mem_addr, iss ? addr_of(q[0]) : last_addr);
        chk("ld_wr", ld_wr, bhit);
        if (bhit) begin
            chk("ld_res_tag", ld_res_tag, sched[0].tag);
            chk("ld_dest", ld_dest, sched[0].dst);
            chk("ld_val", ld_val, sched[0].val);
        end else begin
            chk("ld_val_hold", ld_val, last_val);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        check_outputs();
    endtask

    task automatic idle();
        stall = 0; ld_disp1 = 0; ld_disp2 = 0; base_rdy1 = 0; base_rdy2 = 0;
        base_val1 = 0; base_val2 = 0; base_tag1 = 0; base_tag2 = 0; offset1 = 0; offset2 = 0;
        dest_tag1 = 0; dest_tag2 = 0; dest1 = 0; dest2 = 0;
        alu1_wr = 0; alu2_wr = 0; alu1_res_tag = 0; alu2_res_tag = 0; alu1_res = 0; alu2_res = 0;
    endtask

    task automatic set1(input logic r, input logic [31:0] v, input logic [4:0] bt,
                        input logic [15:0] o, input logic [4:0] dt, input logic [4:0] d);
        ld_disp1 = 1; base_rdy1 = r; base_val1 = v; base_tag1 = bt; offset1 = o; dest_tag1 = dt; dest1 = d;
    endtask
    task automatic set2(input logic r, input logic [31:0] v, input logic [4:0] bt,
                        input logic [15:0] o, input logic [4:0] dt, input logic [4:0] d);
        ld_disp2 = 1; base_rdy2 = r; base_val2 = v; base_tag2 = bt; offset2 = o; dest_tag2 = dt; dest2 = d;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[10'h0FC] = 32'hDEADBEEF;
        mem_rdata = 0;
        idle();
        repeat (2) @(negedge clk);
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_ld_wr", ld_wr, 0);
        chk("rst_ld_tag", ld_res_tag, 0);
        chk("rst_ld_dest", ld_dest, 0);
        chk("rst_ld_val", ld_val, 0);
        chk("rst_full", full_LD, 0);
        rst = 1;
        tick();

        // Single ready load, negative offset
        set1(1, 32'h100, 0, 16'hFFFC, 3, 8); tick(); idle();
        chk("single_rd", mem_rd, 1);
        chk("single_addr", mem_addr, 10'h0FC);
        tick();
        chk("single_nowr", ld_wr, 0);
        tick();
        chk("single_wr", ld_wr, 1);
        chk("single_tag", ld_res_tag, 3);
        chk("single_dest", ld_dest, 8);
        chk("single_val", ld_val, 32'hDEADBEEF);
        tick();
        chk("single_once", ld_wr, 0);

        // Snoop wakeup from alu2
        set1(0, 0, 7, 16'h0004, 1, 2); tick(); idle();
        chk("snoop_wait", mem_rd, 0);
        alu2_wr = 1; alu2_res_tag = 7; alu2_res = 32'h20; tick(); idle();
        chk("snoop_rd", mem_rd, 1);
        chk("snoop_addr", mem_addr, 10'h024);
        repeat (3) tick();

        // Non-ready head blocks a ready younger load
        set1(0, 0, 9, 0, 4, 1); set2(1, 32'h40, 0, 0, 5, 2); tick(); idle();
        tick(); tick();
        chk("block_rd", mem_rd, 0);
        alu1_wr = 1; alu1_res_tag = 9; alu1_res = 32'h80; tick(); idle();
        chk("block_addr0", mem_addr, 10'h080);
        tick();
        chk("block_addr1", mem_addr, 10'h040);
        tick();
        chk("block_tag0", ld_res_tag, 4);
        tick();
        chk("block_wr1", ld_wr, 1);
        chk("block_tag1", ld_res_tag, 5);
        repeat (2) tick();

        // Fill to full, drain, refill across the pointer wrap
        set1(0, 0, 15, 1, 16, 1); set2(0, 0, 15, 2, 17, 2); tick(); idle();
        chk("fill_half", full_LD, 0);
        set1(0, 0, 15, 3, 18, 3); set2(0, 0, 15, 4, 19, 4); tick(); idle();
        chk("fill_full", full_LD, 1);
        alu1_wr = 1; alu1_res_tag = 15; alu1_res = 32'h300; tick(); idle();
        repeat (7) tick();
        set1(1, 32'h10, 0, 0, 20, 5); set2(1, 32'h11, 0, 0, 21, 6); tick(); idle();
        set1(1, 32'h12, 0, 0, 22, 7); set2(1, 32'h13, 0, 0, 23, 8); tick(); idle();
        repeat (8) tick();

        // Load-to-load dependence via ld broadcast
        set1(1, 32'h200, 0, 0, 12, 3); tick(); idle();
        set1(0, 0, 12, 16'h0001, 13, 4); tick(); idle();
        repeat (8) tick();

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            idle();
            stall = ($urandom % 4) == 0;
            if (q.size() <= DEPTH - 2) begin
                if ($urandom % 2) set1($urandom % 2, $urandom, $urandom % 8, $urandom, $urandom % 8, $urandom);
                if ($urandom % 2) set2($urandom % 2, $urandom, $urandom % 8, $urandom, $urandom % 8, $urandom);
            end
            alu1_wr = ($urandom % 3) == 0; alu1_res_tag = $urandom % 8; alu1_res = $urandom;
            alu2_wr = ($urandom % 3) == 0; alu2_res_tag = $urandom % 8; alu2_res = $urandom;
            tick();
        end
        for (int n = 0; n < 40; n++) begin
            idle(); alu1_wr = 1; alu1_res_tag = 5'(n % 8); alu1_res = $urandom; tick();
        end
        idle();

        // Reset with three queued loads and one in flight
        set1(1, 32'h50, 0, 0, 29, 9); set2(0, 0, 30, 0, 24, 1); tick(); idle();
        set1(0, 0, 31, 0, 25, 2); set2(0, 0, 30, 0, 26, 3); tick(); idle();
        rst = 0;
        q.delete(); sched.delete(); last_addr = 0; last_val = 0;
        #1;
        chk("mid_rst_ld_wr", ld_wr, 0);
        chk("mid_rst_mem_rd", mem_rd, 0);
        chk("mid_rst_full", full_LD, 0);
        chk("mid_rst_addr", mem_addr, 0);
        repeat (2) @(negedge clk);
        rst = 1;
        tick();
        chk("post_rst_ld_wr", ld_wr, 0);
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
